// File: rtl/modmul_share_arbiter_pkg.sv
// Shared constants for the mod-q multiplier and its requester arbiter.
package modmul_share_arbiter_pkg;

    localparam int COEF_W    = 16;
    localparam int Q         = 3329;
    localparam int BARRETT_M = 5039;
    localparam int MM_LAT    = 3;

    function automatic int rr_next(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: one-hot grant to the first request at or above ptr.
module rr_arbiter_n #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] id,
    output logic            found
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = ID_W'((int'(ptr) + k) % N);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                id         = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/modmul_share_arbiter.sv
// Shares one pipelined mod-q multiplier among N_REQ requesters and
// routes each reduced result back to the requester that issued it.
module modmul_share_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter int MM_LAT = modmul_share_arbiter_pkg::MM_LAT,
    parameter int Q      = modmul_share_arbiter_pkg::Q
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req_valid,
    input  logic [16*N_REQ-1:0] req_a,
    input  logic [16*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]  req_ready,
    input  logic              hold,
    output logic              mm_valid,
    output logic [15:0]       mm_a,
    output logic [15:0]       mm_b,
    input  logic [15:0]       mm_r,
    output logic [N_REQ-1:0]  resp_valid,
    output logic [15:0]       resp_data,
    output logic              busy,
    output logic              err_range
);

    import modmul_share_arbiter_pkg::*;

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gnt_id;
    logic [N_REQ-1:0]  gnt;
    logic              fire;
    logic [COEF_W-1:0] sel_a;
    logic [COEF_W-1:0] sel_b;
    logic              sel_bad;

    // Tag pipeline: stage k holds the op issued k+1 cycles ago.
    logic [MM_LAT:0]   tag_v;
    logic [ID_W-1:0]   tag_id [MM_LAT+1];

    rr_arbiter_n #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .en    (~hold & ~rst),
        .req   (req_valid),
        .ptr   (ptr),
        .grant (gnt),
        .id    (gnt_id),
        .found (fire)
    );

    assign req_ready = gnt;
    assign sel_a     = req_a[int'(gnt_id)*COEF_W +: COEF_W];
    assign sel_b     = req_b[int'(gnt_id)*COEF_W +: COEF_W];
    assign sel_bad   = (int'(sel_a) >= Q) || (int'(sel_b) >= Q);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            mm_a      <= '0;
            mm_b      <= '0;
            err_range <= 1'b0;
            tag_v     <= '0;
        end else begin
            tag_v <= {tag_v[MM_LAT-1:0], fire};
            if (fire) begin
                ptr  <= ID_W'(rr_next(int'(gnt_id), N_REQ));
                mm_a <= sel_a;
                mm_b <= sel_b;
                if (sel_bad) begin
                    err_range <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= gnt_id;
        for (int k = 1; k <= MM_LAT; k++) begin
            tag_id[k] <= tag_id[k-1];
        end
    end

    assign mm_valid  = tag_v[0];
    assign busy      = |tag_v;
    assign resp_data = mm_r;

    // Results still in flight when reset is asserted are dropped.
    always_comb begin
        resp_valid = '0;
        if (tag_v[MM_LAT] && !rst) begin
            resp_valid = N_REQ'(1) << tag_id[MM_LAT];
        end
    end

endmodule
